step_pulse_monitor: RTL

//  Receive side of the step/dir interface driven by the acceleration step generator.

---
 rtl/step_pulse_monitor.sv | 171 +++++++++++++++++
 1 files changed

// File: rtl/step_pulse_monitor.sv
// Receive-side monitor for a step/dir pulse stream: synchronises the inputs, tracks position and
// step count, measures inter-pulse period, classifies ramp phase and flags target/stall/estop.
module step_pulse_monitor #(
    parameter int unsigned POS_W       = 32,
    parameter int unsigned PER_W       = 24,
    parameter int unsigned STALL_CYC   = 1_000_000,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             step_in,
    input  logic             dir_in,
    input  logic             move,
    input  logic             emergancy,
    input  logic             clear_pos,
    input  logic [POS_W-1:0] target_steps,
    output logic [POS_W-1:0] position,
    output logic [POS_W-1:0] step_count,
    output logic [PER_W-1:0] period,
    output logic             period_valid,
    output logic             accel,
    output logic             decel,
    output logic             at_target,
    output logic             stall,
    output logic             estop
);

    localparam int unsigned IdleW = (STALL_CYC > 1) ? $clog2(STALL_CYC) : 1;
    localparam logic [IdleW-1:0] IdleMax = IdleW'(STALL_CYC - 1);

    typedef enum logic [2:0] {StIdle, StRun, StDone, StStall, StEstop} state_e;

    state_e                 state_q, state_d;
    logic [SYNC_STAGES-1:0] step_sync_q, dir_sync_q;
    logic                   step_prev_q;
    logic [POS_W-1:0]       position_q, position_d;
    logic [POS_W-1:0]       step_count_q, step_count_d;
    logic [PER_W-1:0]       per_cnt_q, per_cnt_d;
    logic [PER_W-1:0]       period_q, period_d;
    logic                   valid_q, valid_d;
    logic                   seen_q, seen_d;
    logic                   accel_q, accel_d;
    logic                   decel_q, decel_d;
    logic [IdleW-1:0]       idle_q, idle_d;

    logic step_s, dir_s, step_rise, evt, counting, clear_eff, start;

    assign step_s    = step_sync_q[SYNC_STAGES-1];
    assign dir_s     = dir_sync_q[SYNC_STAGES-1];
    assign step_rise = step_s & ~step_prev_q;
    // Emergency beats clear, clear beats a coincident step event.
    assign clear_eff = clear_pos & ~emergancy;
    assign evt       = step_rise & ~emergancy & ~clear_pos & (state_q != StEstop);
    assign counting  = evt & (state_q inside {StRun, StDone, StStall});
    assign start     = (state_q == StIdle) && (state_d == StRun);

    always_comb begin
        state_d = state_q;
        if (emergancy) begin
            state_d = StEstop;
        end else begin
            unique case (state_q)
                StIdle:  if (move) state_d = StRun;
                StRun: begin
                    if (!move)                               state_d = StIdle;
                    else if (step_count_q == target_steps)   state_d = StDone;
                    else if (!evt && idle_q == IdleMax)      state_d = StStall;
                end
                StDone:  if (!move) state_d = StIdle;
                StStall: begin
                    if (!move)    state_d = StIdle;
                    else if (evt) state_d = StRun;
                end
                StEstop: if (!move) state_d = StIdle;
                default: state_d = StIdle;
            endcase
        end
    end

    always_comb begin
        position_d   = position_q;
        step_count_d = step_count_q;
        per_cnt_d    = per_cnt_q;
        idle_d       = idle_q;

        if (clear_eff) position_d = '0;
        else if (evt)  position_d = dir_s ? position_q + POS_W'(1) : position_q - POS_W'(1);

        if (clear_eff || state_q == StIdle) step_count_d = '0;
        else if (counting)                  step_count_d = step_count_q + POS_W'(1);

        if (clear_eff || state_q == StIdle) begin
            per_cnt_d = '0;
        end else if (counting) begin
            per_cnt_d = PER_W'(1);
        end else if ((state_q == StRun || state_q == StDone) && per_cnt_q != '1) begin
            per_cnt_d = per_cnt_q + PER_W'(1);
        end

        if (state_q != StRun || evt) idle_d = '0;
        else if (idle_q != IdleMax)  idle_d = idle_q + IdleW'(1);
    end

    // Ramp classification needs the current period to be valid before comparing.
    always_comb begin
        period_d = period_q;
        valid_d  = valid_q;
        seen_d   = seen_q;
        accel_d  = accel_q;
        decel_d  = decel_q;
        if (clear_eff || start) begin
            valid_d = 1'b0;
            seen_d  = 1'b0;
            accel_d = 1'b0;
            decel_d = 1'b0;
            if (clear_eff) period_d = '0;
        end else if (counting) begin
            period_d = per_cnt_q;
            seen_d   = 1'b1;
            valid_d  = seen_q;
            if (valid_q) begin
                accel_d = per_cnt_q < period_q;
                decel_d = per_cnt_q > period_q;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= StIdle;
            step_sync_q  <= '0;
            dir_sync_q   <= '0;
            step_prev_q  <= 1'b0;
            position_q   <= '0;
            step_count_q <= '0;
            per_cnt_q    <= '0;
            period_q     <= '0;
            valid_q      <= 1'b0;
            seen_q       <= 1'b0;
            accel_q      <= 1'b0;
            decel_q      <= 1'b0;
            idle_q       <= '0;
        end else begin
            state_q      <= state_d;
            step_sync_q  <= {step_sync_q[SYNC_STAGES-2:0], step_in};
            dir_sync_q   <= {dir_sync_q[SYNC_STAGES-2:0], dir_in};
            step_prev_q  <= step_s;
            position_q   <= position_d;
            step_count_q <= step_count_d;
            per_cnt_q    <= per_cnt_d;
            period_q     <= period_d;
            valid_q      <= valid_d;
            seen_q       <= seen_d;
            accel_q      <= accel_d;
            decel_q      <= decel_d;
            idle_q       <= idle_d;
        end
    end

    assign position     = position_q;
    assign step_count   = step_count_q;
    assign period       = period_q;
    assign period_valid = valid_q;
    assign accel        = accel_q;
    assign decel        = decel_q;
    assign at_target    = (state_q == StDone) ||
                          (state_q == StRun && step_count_q == target_steps);
    assign stall        = (state_q == StStall);
    assign estop        = (state_q == StEstop);

endmodule
